// File: rtl/vga_timing_pattern.sv
// vga_timing_pattern: programmable VGA raster timing generator with a
// runtime-selectable test-pattern source, running in the pixel clock domain.
//
// Ports:
//   clk, rst      pixel-domain clock, synchronous active-high reset
//   pix_en        pixel advance enable (tie high for one pixel per clk)
//   mode_i        pattern: 0 gradient, 1 colour bars, 2 checkerboard, 3 solid
//   solid_rgb     {r,g,b} colour used by the solid pattern
//   hSync, vSync  syncs, active level set by HS_POL / VS_POL
//   syncB         composite sync to the DAC, held at 0
//   blankB        1 during active video
//   x, y          counter position of the pixel currently on the outputs
//   r, g, b       pixel colour, forced to 0 outside active video
//   frame_start   one-cycle pulse with output pixel (0,0)
module vga_timing_pattern #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 4,
  parameter int CHK_LOG2 = 5,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W     = $clog2(H_TOTAL),
  localparam int Y_W     = $clog2(V_TOTAL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_en,
  input  logic [1:0]             mode_i,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   hSync,
  output logic                   vSync,
  output logic                   syncB,
  output logic                   blankB,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [COLOR_W-1:0]     r,
  output logic [COLOR_W-1:0]     g,
  output logic [COLOR_W-1:0]     b,
  output logic                   frame_start
);

  typedef enum logic [1:0] {
    MODE_GRAD  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  localparam int   BAR_W   = H_ACTIVE / 8;
  localparam int   BC_W    = $clog2(BAR_W + 1);
  localparam int   GB_REM  = (X_W > 2*COLOR_W) ? X_W - 2*COLOR_W : 0;
  localparam logic HS_IDLE = (HS_POL == 0);
  localparam logic VS_IDLE = (VS_POL == 0);

  logic [X_W-1:0]       hcnt_q, hcnt_d;
  logic [Y_W-1:0]       vcnt_q, vcnt_d;
  logic [2:0]           bar_q, bar_d;
  logic [BC_W-1:0]      barcnt_q, barcnt_d;
  mode_e                mode_q, mode_d;
  logic [3*COLOR_W-1:0] solid_q, solid_d;

  logic                 hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, fs_q, fs_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [COLOR_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;

  logic                 line_end, frame_end, active, hs_act, vs_act;
  logic [COLOR_W-1:0]   pix_r, pix_g, pix_b;
  logic [2:0]           bar_code;

  always_comb begin
    line_end  = (int'(hcnt_q) == H_TOTAL - 1);
    frame_end = line_end && (int'(vcnt_q) == V_TOTAL - 1);
    active    = (int'(hcnt_q) < H_ACTIVE) && (int'(vcnt_q) < V_ACTIVE);
    hs_act    = (int'(hcnt_q) >= H_ACTIVE + H_FP) &&
                (int'(hcnt_q) <  H_ACTIVE + H_FP + H_SYNC);
    // vcnt only moves on the hcnt wrap, so this is line-granular by construction
    vs_act    = (int'(vcnt_q) >= V_ACTIVE + V_FP) &&
                (int'(vcnt_q) <  V_ACTIVE + V_FP + V_SYNC);
  end

  always_comb begin
    pix_r    = '0;
    pix_g    = '0;
    pix_b    = '0;
    bar_code = ~bar_q;  // 7 - bar index
    case (mode_q)
      MODE_GRAD: begin
        pix_r = COLOR_W'(hcnt_q);
        pix_g = COLOR_W'(hcnt_q >> COLOR_W);
        // bits above the green field, left-justified into COLOR_W, zero-filled
        pix_b = COLOR_W'({hcnt_q >> (2*COLOR_W), {COLOR_W{1'b0}}} >> GB_REM);
      end
      MODE_BARS: begin
        pix_r = {COLOR_W{bar_code[2]}};
        pix_g = {COLOR_W{bar_code[1]}};
        pix_b = {COLOR_W{bar_code[0]}};
      end
      MODE_CHECK: begin
        if (hcnt_q[CHK_LOG2] ^ vcnt_q[CHK_LOG2]) begin
          pix_r = '1;
          pix_g = '1;
          pix_b = '1;
        end
      end
      MODE_SOLID: {pix_r, pix_g, pix_b} = solid_q;
      default: ;
    endcase
    if (!active) begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
    end
  end

  always_comb begin
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    bar_d    = bar_q;
    barcnt_d = barcnt_q;
    mode_d   = mode_q;
    solid_d  = solid_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    blank_d  = blank_q;
    x_d      = x_q;
    y_d      = y_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    fs_d     = 1'b0;
    if (pix_en) begin
      x_d     = hcnt_q;
      y_d     = vcnt_q;
      blank_d = active;
      hs_d    = hs_act ? ~HS_IDLE : HS_IDLE;
      vs_d    = vs_act ? ~VS_IDLE : VS_IDLE;
      r_d     = pix_r;
      g_d     = pix_g;
      b_d     = pix_b;
      fs_d    = (hcnt_q == '0) && (vcnt_q == '0);
      if (line_end) begin
        hcnt_d   = '0;
        bar_d    = '0;
        barcnt_d = '0;
        vcnt_d   = frame_end ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
        // bar index tracked by a pixel-within-bar counter instead of hcnt / BAR_W
        if (int'(barcnt_q) == BAR_W - 1) begin
          barcnt_d = '0;
          bar_d    = bar_q + 1'b1;
        end else begin
          barcnt_d = barcnt_q + 1'b1;
        end
      end
      if (frame_end) begin
        mode_d  = mode_e'(mode_i);
        solid_d = solid_rgb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      bar_q    <= '0;
      barcnt_q <= '0;
      mode_q   <= MODE_GRAD;
      solid_q  <= '0;
      hs_q     <= HS_IDLE;
      vs_q     <= VS_IDLE;
      blank_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      fs_q     <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      bar_q    <= bar_d;
      barcnt_q <= barcnt_d;
      mode_q   <= mode_d;
      solid_q  <= solid_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      blank_q  <= blank_d;
      x_q      <= x_d;
      y_q      <= y_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      fs_q     <= fs_d;
    end
  end

  assign hSync       = hs_q;
  assign vSync       = vs_q;
  assign syncB       = 1'b0;
  assign blankB      = blank_q;
  assign x           = x_q;
  assign y           = y_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign frame_start = fs_q;

endmodule
